// File: rtl/xbus_pkg.sv
// Shared X-bus definitions: default field widths, the tagged bus word and the
// state encoding of the ifmap tag scatter controller.
package xbus_pkg;

   localparam int DEF_ID_LEN    = 4;
   localparam int DEF_VALUE_LEN = 8;

   typedef struct packed {
      logic [DEF_ID_LEN-1:0]    tag;
      logic [DEF_VALUE_LEN-1:0] value;
   } tag_word_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } scatter_state_e;

endpackage

// File: rtl/ifmap_tag_scatter_if.sv
// X-bus word channel: enable/ready handshake carrying a {tag, value} word.
interface ifmap_tag_scatter_if #(
   parameter int ID_LEN    = xbus_pkg::DEF_ID_LEN,
   parameter int VALUE_LEN = xbus_pkg::DEF_VALUE_LEN
);

   logic                        enable;
   logic [ID_LEN+VALUE_LEN-1:0] tag_value;
   logic                        ready;

   modport master (output enable, output tag_value, input ready);
   modport slave  (input enable, input tag_value, output ready);

endinterface

// File: rtl/ifmap_tag_scatter_sync_fifo.sv
// Show-ahead synchronous FIFO; the head word is visible on dout_o while non-empty
// and full/empty are decoded from the occupancy count.
module sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           din_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push_s, do_pop_s;

   // Qualify the requests and compute next pointers and occupancy.
   always_comb begin
      do_pop_s  = pop_i && (count_q != {CW{1'b0}});
      do_push_s = push_i && ((count_q != DEPTH_C) || do_pop_s);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CW'(1'b1);
         2'b01:   count_d = count_q - CW'(1'b1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are meaningless while empty, so no reset.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   assign empty_o = (count_q == {CW{1'b0}});
   assign full_o  = (count_q == DEPTH_C);
   assign count_o = count_q;
   assign dout_o  = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

endmodule

// File: rtl/ifmap_tag_scatter.sv
// Reads an ifmap tile from the GLB in column-major order, tags each value with its
// row and streams {tag, value} words onto the X-bus through a credit-limited FIFO.
module ifmap_tag_scatter
   import xbus_pkg::*;
#(
   parameter int ID_LEN     = DEF_ID_LEN,
   parameter int VALUE_LEN  = DEF_VALUE_LEN,
   parameter int ADDR_LEN   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_LEN-1:0]  base_addr,
   input  logic [ID_LEN-1:0]    num_rows,
   input  logic [ADDR_LEN-1:0]  row_len,
   output logic                 busy,
   output logic                 done,
   output logic                 glb_rd_en,
   output logic [ADDR_LEN-1:0]  glb_rd_addr,
   input  logic [VALUE_LEN-1:0] glb_rd_data,
   ifmap_tag_scatter_if.master  xbus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int WW = ID_LEN + VALUE_LEN;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   scatter_state_e      state_q, state_d;
   logic [ID_LEN-1:0]   r_q, r_d;
   logic [ID_LEN-1:0]   last_row_q, last_row_d;
   logic [ID_LEN-1:0]   tag_q, tag_d;
   logic [ADDR_LEN-1:0] c_q, c_d;
   logic [ADDR_LEN-1:0] last_col_q, last_col_d;
   logic [ADDR_LEN-1:0] row_len_q, row_len_d;
   logic [ADDR_LEN-1:0] col_addr_q, col_addr_d;
   logic [ADDR_LEN-1:0] row_addr_q, row_addr_d;
   logic                inflight_q, inflight_d;
   logic                done_q, done_d;

   logic                tile_empty_s, accept_s, credit_s, issue_s;
   logic                last_elem_s, drained_s, pop_s;
   logic [CW:0]         occ_s;
   logic                fifo_full_s, fifo_empty_s;
   logic [CW-1:0]       fifo_count_s;
   logic [WW-1:0]       fifo_din_s, fifo_dout_s;

   // Tile decode and read credit: FIFO words plus the in-flight read never exceed the depth.
   always_comb begin
      tile_empty_s = (num_rows == {ID_LEN{1'b0}}) || (row_len == {ADDR_LEN{1'b0}});
      accept_s     = (state_q == ST_IDLE) && start;
      occ_s        = {1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_q};
      credit_s     = !fifo_full_s && (occ_s < DEPTH_C);
      last_elem_s  = (r_q == last_row_q) && (c_q == last_col_q);
      drained_s    = !inflight_q && fifo_empty_s;
      pop_s        = !fifo_empty_s && xbus.ready;
   end

   // Controller next state, read issue and completion pulse.
   always_comb begin
      state_d = state_q;
      issue_s = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               if (tile_empty_s) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_ISSUE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (credit_s) begin
               issue_s = 1'b1;
               if (last_elem_s) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_ISSUE;
               end
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (drained_s) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Address walk: row_addr accumulates the stride per row and restarts one past the column base.
   always_comb begin
      r_d        = r_q;
      c_d        = c_q;
      last_row_d = last_row_q;
      last_col_d = last_col_q;
      row_len_d  = row_len_q;
      col_addr_d = col_addr_q;
      row_addr_d = row_addr_q;
      inflight_d = issue_s;
      tag_d      = tag_q;
      if (accept_s && !tile_empty_s) begin
         r_d        = {ID_LEN{1'b0}};
         c_d        = {ADDR_LEN{1'b0}};
         last_row_d = num_rows - ID_LEN'(1'b1);
         last_col_d = row_len - ADDR_LEN'(1'b1);
         row_len_d  = row_len;
         col_addr_d = base_addr;
         row_addr_d = base_addr;
      end else if (issue_s) begin
         tag_d = r_q;
         if (r_q == last_row_q) begin
            r_d        = {ID_LEN{1'b0}};
            c_d        = c_q + ADDR_LEN'(1'b1);
            col_addr_d = col_addr_q + ADDR_LEN'(1'b1);
            row_addr_d = col_addr_q + ADDR_LEN'(1'b1);
         end else begin
            r_d        = r_q + ID_LEN'(1'b1);
            row_addr_d = row_addr_q + row_len_q;
         end
      end else begin
         tag_d = tag_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         r_q        <= {ID_LEN{1'b0}};
         c_q        <= {ADDR_LEN{1'b0}};
         last_row_q <= {ID_LEN{1'b0}};
         last_col_q <= {ADDR_LEN{1'b0}};
         row_len_q  <= {ADDR_LEN{1'b0}};
         col_addr_q <= {ADDR_LEN{1'b0}};
         row_addr_q <= {ADDR_LEN{1'b0}};
         inflight_q <= 1'b0;
         tag_q      <= {ID_LEN{1'b0}};
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         c_q        <= c_d;
         last_row_q <= last_row_d;
         last_col_q <= last_col_d;
         row_len_q  <= row_len_d;
         col_addr_q <= col_addr_d;
         row_addr_q <= row_addr_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
         done_q     <= done_d;
      end
   end

   assign fifo_din_s = {tag_q, glb_rd_data};

   sync_fifo #(
      .WIDTH (WW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (inflight_q),
      .pop_i   (pop_s),
      .din_i   (fifo_din_s),
      .dout_o  (fifo_dout_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

   assign busy           = (state_q != ST_IDLE);
   assign done           = done_q;
   assign glb_rd_en      = issue_s;
   assign glb_rd_addr    = row_addr_q;
   assign xbus.enable    = !fifo_empty_s;
   assign xbus.tag_value = fifo_dout_s;

endmodule

// File: tb/tb_ifmap_tag_scatter.sv
// Self-checking bench for ifmap_tag_scatter: GLB model, random ready patterns and a
// column-major stream reference built from tile geometry with plain arithmetic.
`timescale 1ns/1ps
module tb_ifmap_tag_scatter;
   import xbus_pkg::*;

   localparam int LIMIT = 2000;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, start, busy, done, glb_rd_en;
   logic [15:0] base_addr, row_len, glb_rd_addr;
   logic [3:0]  num_rows;
   logic [7:0]  glb_rd_data;
   logic [7:0]  glb_mem [0:65535];

   ifmap_tag_scatter_if #(.ID_LEN(4), .VALUE_LEN(8)) xbus ();

   ifmap_tag_scatter #(.ID_LEN(4), .VALUE_LEN(8), .ADDR_LEN(16), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
      .row_len(row_len), .busy(busy), .done(done), .glb_rd_en(glb_rd_en),
      .glb_rd_addr(glb_rd_addr), .glb_rd_data(glb_rd_data), .xbus(xbus)
   );

   always #5 clk = ~clk;

   // GLB: data one cycle after a request, junk otherwise.
   always @(posedge clk) glb_rd_data <= glb_rd_en ? glb_mem[glb_rd_addr] : 8'($urandom);

   logic [11:0] got_q [$];
   logic [15:0] addr_q [$];
   logic [11:0] exp_q [$];
   int rd_total = 0, done_total = 0, occ = 0, credit_viol = 0, stab_viol = 0;
   logic hold_q = 1'b0;
   logic [11:0] hold_word = 12'h000;
   int vectors = 0, miscompares = 0;

   // Bus/GLB monitor: transfers, read addresses, occupancy and hold stability.
   always @(posedge clk) begin
      if (glb_rd_en && !rst) addr_q.push_back(glb_rd_addr);
      if (xbus.enable && xbus.ready && !rst) got_q.push_back(xbus.tag_value);
      rd_total   <= rd_total + ((glb_rd_en && !rst) ? 1 : 0);
      done_total <= done_total + (done ? 1 : 0);
      if (glb_rd_en && !rst && occ >= DEPTH) credit_viol <= credit_viol + 1;
      occ <= rst ? 0 : occ + (glb_rd_en ? 1 : 0) - ((xbus.enable && xbus.ready) ? 1 : 0);
      if (hold_q && !rst && (xbus.enable !== 1'b1 || xbus.tag_value !== hold_word))
         stab_viol <= stab_viol + 1;
      hold_q    <= xbus.enable && !xbus.ready && !rst;
      hold_word <= xbus.tag_value;
   end

   function automatic logic ready_for(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return ((k % 4) == 0) || ((k % 4) == 3);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic fill_mem(input bit rand_fill);
      for (int a = 0; a < 65536; a++) glb_mem[a] = rand_fill ? 8'($urandom) : 8'(a);
   endtask

   task automatic build_exp(input logic [15:0] base, input int nr, input int nc);
      tag_word_t   w;
      logic [15:0] a;
      exp_q.delete();
      for (int c = 0; c < nc; c++)
         for (int r = 0; r < nr; r++) begin
            a = base + 16'(c) + 16'(r * nc);
            w.tag = 4'(r);
            w.value = glb_mem[a];
            exp_q.push_back(w);
         end
   endtask

   task automatic kick(input logic [15:0] base, input int nr, input int nc);
      @(negedge clk);
      start = 1'b1; base_addr = base; num_rows = 4'(nr); row_len = 16'(nc);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_until_done(input int mode, input int cyc0, output int cyc, output int first_en);
      cyc = cyc0; first_en = -1;
      while (!done && cyc < LIMIT) begin
         if (xbus.enable && first_en < 0) first_en = cyc;
         xbus.ready = ready_for(mode, cyc);
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; base_addr = 16'h0; num_rows = 4'h0; row_len = 16'h0;
      xbus.ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({busy, done, glb_rd_en, xbus.enable} !== 4'b0000 || glb_rd_addr !== 16'h0 || xbus.tag_value !== 12'h0) begin
         miscompares++;
         $display("FAIL reset_state: got busy=%b done=%b rd_en=%b en=%b addr=%h tv=%h want all zero",
                  busy, done, glb_rd_en, xbus.enable, glb_rd_addr, xbus.tag_value);
      end
      xbus.ready = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (xbus.enable !== 1'b0 || got_q.size() !== 0) begin
         miscompares++;
         $display("FAIL idle_ready: got en=%b xfers=%0d want 0 0", xbus.enable, got_q.size());
      end
   endtask

   task automatic test_basic();
      int xb, db, cyc, fe;
      fill_mem(1'b0);
      build_exp(16'h0100, 7, 2);
      xb = got_q.size(); db = done_total;
      xbus.ready = 1'b1;
      kick(16'h0100, 7, 2);
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b want 1", busy); end
      run_until_done(0, 1, cyc, fe);
      vectors++;
      if (fe !== 3) begin miscompares++; $display("FAIL basic_first_enable: got cycle %0d want 3", fe); end
      vectors++;
      if (cyc !== 18) begin miscompares++; $display("FAIL basic_done_cycle: got %0d want 18", cyc); end
      @(negedge clk);
      vectors++;
      if (got_q.size() - xb !== 14) begin
         miscompares++; $display("FAIL basic_count: got %0d want 14", got_q.size() - xb);
      end else
         for (int i = 0; i < 14; i++) begin
            vectors++;
            if (got_q[xb+i] !== exp_q[i]) begin
               miscompares++; $display("FAIL basic_word%0d: got %h want %h", i, got_q[xb+i], exp_q[i]);
            end
         end
      vectors++;
      if (done_total - db !== 1 || done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_done_pulse: got pulses=%0d done=%b busy=%b want 1 0 0", done_total - db, done, busy);
      end
   endtask

   task automatic test_backpressure();
      int xb, cv, sv, cyc, fe;
      build_exp(16'h0100, 7, 2);
      xb = got_q.size(); cv = credit_viol; sv = stab_viol;
      xbus.ready = 1'b1;
      kick(16'h0100, 7, 2);
      run_until_done(1, 1, cyc, fe);
      @(negedge clk);
      vectors++;
      if (cyc >= LIMIT || got_q.size() - xb !== 14) begin
         miscompares++; $display("FAIL bp_count: got %0d words cyc=%0d want 14", got_q.size() - xb, cyc);
      end else
         for (int i = 0; i < 14; i++) begin
            vectors++;
            if (got_q[xb+i] !== exp_q[i]) begin
               miscompares++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[xb+i], exp_q[i]);
            end
         end
      vectors++;
      if (stab_viol - sv !== 0 || credit_viol - cv !== 0) begin
         miscompares++;
         $display("FAIL bp_rules: got stability=%0d credit=%0d violations want 0 0", stab_viol - sv, credit_viol - cv);
      end
   endtask

   task automatic test_stall_full();
      int xb, rb, cyc, fe;
      build_exp(16'h0100, 7, 2);
      xb = got_q.size(); rb = rd_total;
      xbus.ready = 1'b0;
      kick(16'h0100, 7, 2);
      repeat (9) @(negedge clk);
      vectors++;
      if (rd_total - rb !== 4 || xbus.enable !== 1'b1 || xbus.tag_value !== 12'h000) begin
         miscompares++;
         $display("FAIL stall_full: got reads=%0d en=%b tv=%h want 4 1 000", rd_total - rb, xbus.enable, xbus.tag_value);
      end
      run_until_done(0, 10, cyc, fe);
      @(negedge clk);
      vectors++;
      if (cyc >= LIMIT || got_q.size() - xb !== 14) begin
         miscompares++; $display("FAIL stall_count: got %0d words cyc=%0d want 14", got_q.size() - xb, cyc);
      end else
         for (int i = 0; i < 14; i++) begin
            vectors++;
            if (got_q[xb+i] !== exp_q[i]) begin
               miscompares++; $display("FAIL stall_word%0d: got %h want %h", i, got_q[xb+i], exp_q[i]);
            end
         end
   endtask

   task automatic test_empty_tile();
      int rb;
      for (int k = 0; k < 2; k++) begin
         rb = rd_total;
         xbus.ready = 1'b1;
         if (k == 0) kick(16'h0040, 0, 3); else kick(16'h0040, 7, 0);
         vectors++;
         if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL empty%0d_pulse: got done=%b busy=%b want 1 0", k, done, busy);
         end
         @(negedge clk);
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0 || rd_total - rb !== 0) begin
            miscompares++;
            $display("FAIL empty%0d_after: got done=%b busy=%b reads=%0d want 0 0 0", k, done, busy, rd_total - rb);
         end
      end
   endtask

   task automatic test_reset_mid_tile();
      int xb, db, n, cyc, fe;
      build_exp(16'h0100, 7, 2);
      xb = got_q.size();
      xbus.ready = 1'b1;
      kick(16'h0100, 7, 2);
      n = 0;
      while (got_q.size() - xb < 5 && n < 100) begin @(negedge clk); n++; end
      rst = 1'b1; xbus.ready = 1'b0;
      @(negedge clk);
      rst = 1'b0; db = done_total;
      vectors++;
      if (xbus.enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || got_q.size() - xb !== 5) begin
         miscompares++;
         $display("FAIL rstmid_abort: got en=%b busy=%b done=%b xfers=%0d want 0 0 0 5",
                  xbus.enable, busy, done, got_q.size() - xb);
      end
      for (int i = 0; i < 5 && got_q.size() - xb >= 5; i++) begin
         vectors++;
         if (got_q[xb+i] !== exp_q[i]) begin
            miscompares++; $display("FAIL rstmid_pre%0d: got %h want %h", i, got_q[xb+i], exp_q[i]);
         end
      end
      repeat (4) @(negedge clk);
      vectors++;
      if (done_total - db !== 0 || xbus.enable !== 1'b0) begin
         miscompares++; $display("FAIL rstmid_quiet: got pulses=%0d en=%b want 0 0", done_total - db, xbus.enable);
      end
      xb = got_q.size();
      xbus.ready = 1'b1;
      kick(16'h0100, 7, 2);
      run_until_done(0, 1, cyc, fe);
      @(negedge clk);
      vectors++;
      if (cyc !== 18 || got_q.size() - xb !== 14) begin
         miscompares++; $display("FAIL rstmid_restart: got cyc=%0d words=%0d want 18 14", cyc, got_q.size() - xb);
      end else
         for (int i = 0; i < 14; i++) begin
            vectors++;
            if (got_q[xb+i] !== exp_q[i]) begin
               miscompares++; $display("FAIL rstmid_word%0d: got %h want %h", i, got_q[xb+i], exp_q[i]);
            end
         end
   endtask

   task automatic test_wrap_ignored_start();
      int xb, ab, rb, cyc, fe;
      logic [15:0] want_addr [4];
      want_addr[0] = 16'hFFFE; want_addr[1] = 16'h0000; want_addr[2] = 16'hFFFF; want_addr[3] = 16'h0001;
      fill_mem(1'b1);
      build_exp(16'hFFFE, 2, 2);
      xb = got_q.size(); ab = addr_q.size(); rb = rd_total;
      xbus.ready = 1'b1;
      kick(16'hFFFE, 2, 2);
      start = 1'b1; base_addr = 16'h1234; num_rows = 4'd5; row_len = 16'd3;
      @(negedge clk);
      start = 1'b0;
      run_until_done(1, 2, cyc, fe);
      repeat (4) @(negedge clk);
      vectors++;
      if (cyc >= LIMIT || got_q.size() - xb !== 4 || rd_total - rb !== 4 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_count: got words=%0d reads=%0d busy=%b cyc=%0d want 4 4 0",
                  got_q.size() - xb, rd_total - rb, busy, cyc);
      end else
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (addr_q[ab+i] !== want_addr[i] || got_q[xb+i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL wrap_%0d: got addr=%h word=%h want %h %h", i, addr_q[ab+i], got_q[xb+i], want_addr[i], exp_q[i]);
            end
         end
   endtask

   task automatic test_random_tiles();
      int xb, rb, cv, sv, cyc, fe, nr, nc;
      logic [15:0] base;
      for (int t = 0; t < 6; t++) begin
         nr = (t == 0) ? 15 : $urandom_range(1, 15);
         nc = (t == 0) ? 1 : $urandom_range(1, 5);
         base = 16'($urandom);
         build_exp(base, nr, nc);
         xb = got_q.size(); rb = rd_total; cv = credit_viol; sv = stab_viol;
         kick(base, nr, nc);
         run_until_done(2, 1, cyc, fe);
         @(negedge clk);
         vectors++;
         if (cyc >= LIMIT || got_q.size() - xb !== nr * nc || rd_total - rb !== nr * nc) begin
            miscompares++;
            $display("FAIL rand%0d_count: got words=%0d reads=%0d cyc=%0d want %0d", t, got_q.size() - xb,
                     rd_total - rb, cyc, nr * nc);
         end else
            for (int i = 0; i < nr * nc; i++) begin
               vectors++;
               if (got_q[xb+i] !== exp_q[i]) begin
                  miscompares++; $display("FAIL rand%0d_word%0d: got %h want %h", t, i, got_q[xb+i], exp_q[i]);
               end
            end
         vectors++;
         if (stab_viol - sv !== 0 || credit_viol - cv !== 0) begin
            miscompares++;
            $display("FAIL rand%0d_rules: got stability=%0d credit=%0d want 0 0", t, stab_viol - sv, credit_viol - cv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_stall_full();
      test_empty_tile();
      test_reset_mid_tile();
      test_wrap_ignored_start();
      test_random_tiles();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
